// File: rtl/user_lookup.sv
// User-credential lookup: scans a 1-cycle-latency ROM for the latched ID and reports hit/level.
// Optional consecutive-miss lockout is enabled with `define USER_LOOKUP_LOCKOUT_EN.
module user_lookup #(
    parameter int unsigned ID_W        = 4,
    parameter int unsigned LVL_W       = 2,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEFAULT_LVL = 0,
    parameter int unsigned MAX_LVL     = 2,
    parameter int unsigned MAX_FAIL    = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ID_W-1:0]         user_i,
    input  logic                    load_i,
    output logic [ADDR_W-1:0]       rom_addr_o,
    input  logic [ID_W+LVL_W-1:0]   rom_data_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    found_o,
    output logic [LVL_W-1:0]        level_o,
    output logic                    user_log_o,
    output logic                    locked_o
);

    typedef enum logic [1:0] {StIdle, StWait, StCmp, StDone} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    user_q, user_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               found_q, found_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               user_log_q, user_log_d;
    logic               locked;
    logic [ID_W-1:0]    rom_id;
    logic [LVL_W-1:0]   rom_lvl;

    assign rom_id  = rom_data_i[ID_W-1:0];
    assign rom_lvl = rom_data_i[ID_W+LVL_W-1:ID_W];

    always_comb begin
        state_d    = state_q;
        user_d     = user_q;
        addr_d     = addr_q;
        found_d    = found_q;
        level_d    = level_q;
        user_log_d = user_log_q;
        case (state_q)
            StIdle: begin
                if (load_i) begin
                    user_d  = user_i;
                    addr_d  = '0;
                    found_d = 1'b0;
                    level_d = LVL_W'(DEFAULT_LVL);
                    state_d = locked ? StDone : StWait;
                end
            end
            StWait: state_d = StCmp;
            StCmp: begin
                // End marker outranks an ID match, so an all-ones user never hits.
                if (rom_id == '1) begin
                    state_d = StDone;
                end else if (rom_id == user_q) begin
                    found_d = 1'b1;
                    level_d = (rom_lvl <= LVL_W'(MAX_LVL)) ? rom_lvl : LVL_W'(DEFAULT_LVL);
                    state_d = StDone;
                end else if (addr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = StWait;
                end
            end
            StDone: begin
                user_log_d = 1'b1;
                addr_d     = '0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            user_q     <= '0;
            addr_q     <= '0;
            found_q    <= 1'b0;
            level_q    <= LVL_W'(DEFAULT_LVL);
            user_log_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            user_q     <= user_d;
            addr_q     <= addr_d;
            found_q    <= found_d;
            level_q    <= level_d;
            user_log_q <= user_log_d;
        end
    end

`ifdef USER_LOOKUP_LOCKOUT_EN
    localparam int unsigned FailW = $clog2(MAX_FAIL + 1);

    logic [FailW-1:0] fail_q, fail_d;
    logic             locked_q, locked_d;

    // Outcome of a lookup is final in StDone; update the saturating miss count there.
    always_comb begin
        fail_d   = fail_q;
        locked_d = locked_q;
        if (state_q == StDone) begin
            if (found_q) begin
                fail_d = '0;
            end else if (fail_q < FailW'(MAX_FAIL)) begin
                fail_d = fail_q + 1'b1;
            end
            if (!found_q && fail_d == FailW'(MAX_FAIL)) begin
                locked_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fail_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            fail_q   <= fail_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;
`else
    // MAX_FAIL only matters when lockout is built in.
    logic unused_max_fail;
    assign unused_max_fail = ^MAX_FAIL;
    assign locked          = 1'b0;
`endif

    assign rom_addr_o = addr_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);
    assign found_o    = found_q;
    assign level_o    = level_q;
    assign user_log_o = user_log_q;
    assign locked_o   = locked;

endmodule

// File: tb/tb_user_lookup.sv
// Self-checking bench for user_lookup: directed scenarios plus randomized tables/users
// compared against a table-walking reference model.
module tb_user_lookup;

`ifdef USER_LOOKUP_LOCKOUT_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif
    localparam int MaxFail = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] user, user2;
    logic       load, load2;
    logic [7:0] rom_addr, rom_addr2;
    logic [5:0] rom_data, rom_data2;
    logic       busy, done, found, user_log, locked;
    logic       busy2, done2, found2, user_log2, locked2;
    logic [1:0] level, level2;

    logic [5:0] rom [0:255];

    int checks   = 0;
    int failures = 0;
    int fail_m   = 0;
    bit locked_m = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data  <= rom[rom_addr];
        rom_data2 <= rom[rom_addr2];
    end

    user_lookup #(.DEPTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .user_i(user), .load_i(load),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data), .busy_o(busy), .done_o(done),
        .found_o(found), .level_o(level), .user_log_o(user_log), .locked_o(locked)
    );

    user_lookup #(.DEPTH(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .user_i(user2), .load_i(load2),
        .rom_addr_o(rom_addr2), .rom_data_i(rom_data2), .busy_o(busy2), .done_o(done2),
        .found_o(found2), .level_o(level2), .user_log_o(user_log2), .locked_o(locked2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk the table as the login rules describe; done cycle is 3 + 2*(entries examined - 1).
    function automatic void ref_lookup(input logic [3:0] u, input int depth, output int cyc,
                                       output bit hit, output logic [1:0] lvl);
        logic [5:0] e;
        hit = 1'b0;
        lvl = 2'd0;
        cyc = 1;
        if (locked_m) return;
        for (int k = 0; k < depth; k++) begin
            e   = rom[k];
            cyc = 3 + 2 * k;
            if (e[3:0] == 4'hF) return;
            if (e[3:0] == u) begin
                hit = 1'b1;
                lvl = (e[5:4] <= 2'd2) ? e[5:4] : 2'd0;
                return;
            end
        end
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        fail_m   = 0;
        locked_m = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns the observed done cycle.
    task automatic run_lookup(input logic [3:0] u, input bit noise, output int cyc);
        int         exp_cyc;
        bit         exp_hit;
        logic [1:0] exp_lvl;
        int         n;
        ref_lookup(u, 16, exp_cyc, exp_hit, exp_lvl);
        user = u;
        load = 1'b1;
        @(negedge clk);
        n = 1;
        while (1) begin
            load = noise && (n <= 4);
            if (noise) user = 4'h3;
            if (done === 1'b1 || n >= 100) break;
            if (n == 1) check("found_cleared", found, 0);
            @(negedge clk);
            n++;
        end
        load = 1'b0;
        check("done_cycle", n, exp_cyc);
        check("found", found, exp_hit);
        check("level", level, exp_lvl);
        check("busy_in_done", busy, 1);
        if (exp_hit) fail_m = 0;
        else if (fail_m < MaxFail) fail_m++;
        if (LockEn && fail_m >= MaxFail) locked_m = 1'b1;
        @(negedge clk);
        check("done_pulse_end", done, 0);
        check("busy_idle", busy, 0);
        check("user_log", user_log, 1);
        check("locked", locked, locked_m);
        check("found_held", found, exp_hit);
        check("addr_idle", rom_addr, 0);
        cyc = n;
    endtask

    initial begin
        int  c;
        int  n;
        bit  seen;
        bit  over;
        logic [3:0] u;

        rst = 1'b1; load = 1'b0; user = 4'h0; load2 = 1'b0; user2 = 4'h0;
        for (int i = 0; i < 256; i++) rom[i] = 6'h0F;
        rom[0] = {2'd1, 4'h3};
        rom[1] = {2'd2, 4'h5};
        rom[2] = {2'd3, 4'h7};
        rom[3] = {2'd0, 4'hF};
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_addr", rom_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_level", level, 0);
        check("rst_user_log", user_log, 0);
        check("rst_locked", locked, 0);

        run_lookup(4'h3, 1'b0, c); check("u3_cycle", c, 3);
        run_lookup(4'h5, 1'b0, c); check("u5_cycle", c, 5);
        run_lookup(4'h7, 1'b0, c); check("u7_cycle", c, 7);
        run_lookup(4'h9, 1'b0, c); check("u9_cycle", c, 9);
        run_lookup(4'hF, 1'b0, c); check("uF_cycle", c, 9);
        run_lookup(4'h3, 1'b0, c);
        run_lookup(4'h5, 1'b1, c); check("ignored_load_cycle", c, 5);

        // Reset during a scan: no done, everything back to reset values.
        user = 4'h5; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; fail_m = 0; locked_m = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_found", found, 0);
        check("abort_level", level, 0);
        check("abort_user_log", user_log, 0);
        check("abort_addr", rom_addr, 0);
        check("abort_locked", locked, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", seen, 0);

        // Short table: exhausted at entry 1 without touching address 2.
        user2 = 4'h7; load2 = 1'b1;
        @(negedge clk);
        load2 = 1'b0;
        n = 1; over = 1'b0;
        while (done2 !== 1'b1 && n < 50) begin
            if (rom_addr2 >= 8'd2) over = 1'b1;
            @(negedge clk);
            n++;
        end
        check("d2_cycle", n, 5);
        check("d2_found", found2, 0);
        check("d2_level", level2, 0);
        check("d2_busy", busy2, 1);
        check("d2_addr_bound", over, 0);
        @(negedge clk);
        check("d2_user_log", user_log2, 1);
        check("d2_locked", locked2, 0);

        // Lockout after consecutive misses (or none without the feature).
        do_reset();
        for (int i = 0; i < 3; i++) run_lookup(4'h9, 1'b0, c);
        check("lock_after_misses", locked, LockEn);
        run_lookup(4'h3, 1'b0, c);
        check("locked_req_cycle", c, LockEn ? 1 : 3);
        do_reset();
        check("lock_cleared", locked, 0);
        run_lookup(4'h3, 1'b0, c);
        check("relogin_cycle", c, 3);

        // Random tables and users against the reference model.
        for (int i = 0; i < 30; i++) begin
            if (i % 6 == 0) begin
                for (int k = 0; k < 16; k++)
                    rom[k] = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            end
            if (locked_m && (i % 4 == 0)) do_reset();
            if ($urandom_range(0, 1) == 1) begin
                c = $urandom_range(0, 15);
                u = rom[c][3:0];
            end else begin
                u = 4'($urandom_range(0, 15));
            end
            run_lookup(u, 1'b0, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
